simd_round_ctrl: RTL and testbench

SIMD_ROUND_CTRL -- requirements
Module: simd_round_ctrl

---
 rtl/simd_round_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_simd_round_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_round_ctrl.sv
// SIMD round sequencer: 32 FETCH/EXEC steps over an external step datapath; SIMD_FEEDFORWARD_EN adds 4 IV feed-forward steps.
// Two cycles per step, EXEC stalls while w_valid is low, done pulses one cycle after the last EXEC.
module simd_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] iv_a,
  input  logic [127:0] iv_b,
  input  logic [127:0] iv_c,
  input  logic [127:0] iv_d,
  output logic [4:0]   w_addr,
  input  logic [127:0] w_data,
  input  logic         w_valid,
  output logic [127:0] step_ia,
  output logic [127:0] step_ib,
  output logic [127:0] step_ic,
  output logic [127:0] step_id,
  output logic [4:0]   step_r,
  output logic [4:0]   step_s,
  output logic [4:0]   step_rp,
  output logic [4:0]   step_sp,
  output logic [127:0] step_w,
  output logic [1:0]   step_i,
  output logic         step_f,
  input  logic [127:0] step_oa,
  input  logic [127:0] step_ob,
  input  logic [127:0] step_oc,
  input  logic [127:0] step_od,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_a,
  output logic [127:0] out_b,
  output logic [127:0] out_c,
  output logic [127:0] out_d
);

`ifdef SIMD_FEEDFORWARD_EN
  localparam int SW = 6;
  localparam logic [SW-1:0] LAST_STEP = 6'd35;
`else
  localparam int SW = 5;
  localparam logic [SW-1:0] LAST_STEP = 5'd31;
`endif
  localparam logic [SW-1:0] STEP_ONE = 1;

  // Rotation table, entry {round,idx} at bit offset 5*{round,idx}.
  localparam logic [79:0] PI_TAB = {5'd25, 5'd10, 5'd13, 5'd4,
                                    5'd5,  5'd15, 5'd9,  5'd29,
                                    5'd7,  5'd22, 5'd19, 5'd28,
                                    5'd27, 5'd17, 5'd23, 5'd3};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t          state_q;
  logic            busy_q, done_q;
  logic [SW-1:0]   step_q, step_d;
  logic [1:0]      mod3_q, mod3_d;
  logic [127:0]    a_q, b_q, c_q, d_q;
  logic [127:0]    oa_q, ob_q, oc_q, od_q;
  logic            ff_phase;
  logic [127:0]    ff_w;
  logic [1:0]      rnd;
  logic [4:0]      r_raw, s_raw;

`ifdef SIMD_FEEDFORWARD_EN
  logic [127:0] sv_a_q, sv_b_q, sv_c_q, sv_d_q;

  assign ff_phase = step_q[5];
  assign w_addr   = ff_phase ? 5'd31 : step_q[4:0];

  always_comb begin
    ff_w = sv_a_q;
    case (step_q[1:0])
      2'd1:    ff_w = sv_b_q;
      2'd2:    ff_w = sv_c_q;
      2'd3:    ff_w = sv_d_q;
      default: ff_w = sv_a_q;
    endcase
  end
`else
  assign ff_phase = 1'b0;
  assign ff_w     = '0;
  assign w_addr   = step_q;
`endif

  assign step_d = step_q + STEP_ONE;
  assign mod3_d = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;

  assign rnd   = ff_phase ? 2'd3 : step_q[4:3];
  assign r_raw = PI_TAB[7'({rnd, step_q[1:0]}) * 7'd5 +: 5];
  assign s_raw = PI_TAB[7'({rnd, step_q[1:0] + 2'd1}) * 7'd5 +: 5];

  // Controls are forced to zero outside a run so the datapath sees a quiet bus.
  assign step_r  = busy_q ? r_raw : 5'd0;
  assign step_s  = busy_q ? s_raw : 5'd0;
  assign step_rp = 5'd0 - step_r;
  assign step_sp = 5'd0 - step_s;
  assign step_f  = busy_q & ~ff_phase & step_q[2];
  assign step_i  = busy_q ? mod3_q : 2'd0;
  assign step_w  = (state_q == S_EXEC) ? (ff_phase ? ff_w : w_data) : '0;

  assign step_ia = a_q;
  assign step_ib = b_q;
  assign step_ic = c_q;
  assign step_id = d_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign out_a   = oa_q;
  assign out_b   = ob_q;
  assign out_c   = oc_q;
  assign out_d   = od_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      mod3_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      oc_q    <= '0;
      od_q    <= '0;
`ifdef SIMD_FEEDFORWARD_EN
      sv_a_q  <= '0;
      sv_b_q  <= '0;
      sv_c_q  <= '0;
      sv_d_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= iv_a;
            b_q     <= iv_b;
            c_q     <= iv_c;
            d_q     <= iv_d;
            step_q  <= '0;
            mod3_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
`ifdef SIMD_FEEDFORWARD_EN
            sv_a_q  <= iv_a;
            sv_b_q  <= iv_b;
            sv_c_q  <= iv_c;
            sv_d_q  <= iv_d;
`endif
          end
        end
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          // Feed-forward words come from saved IVs, so those steps never wait.
          if (w_valid || ff_phase) begin
            a_q    <= step_oa;
            b_q    <= step_ob;
            c_q    <= step_oc;
            d_q    <= step_od;
            step_q <= step_d;
            mod3_q <= mod3_d;
            if (step_q == LAST_STEP) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              oa_q    <= step_oa;
              ob_q    <= step_ob;
              oc_q    <= step_oc;
              od_q    <= step_od;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_round_ctrl.sv
// Randomized bench for simd_round_ctrl with a behavioural step-by-step reference model.
module tb_simd_round_ctrl;
`ifdef SIMD_FEEDFORWARD_EN
  localparam int NSTEPS = 36;
`else
  localparam int NSTEPS = 32;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, w_valid = 1'b0;
  logic [127:0] iv_a = '0, iv_b = '0, iv_c = '0, iv_d = '0;
  logic [4:0]   w_addr;
  logic [127:0] w_data;
  logic [127:0] step_ia, step_ib, step_ic, step_id, step_w;
  logic [4:0]   step_r, step_s, step_rp, step_sp;
  logic [1:0]   step_i;
  logic         step_f, busy, done;
  logic [127:0] step_oa, step_ob, step_oc, step_od;
  logic [127:0] out_a, out_b, out_c, out_d;

  simd_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .iv_a(iv_a), .iv_b(iv_b), .iv_c(iv_c), .iv_d(iv_d),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid),
    .step_ia(step_ia), .step_ib(step_ib), .step_ic(step_ic), .step_id(step_id),
    .step_r(step_r), .step_s(step_s), .step_rp(step_rp), .step_sp(step_sp),
    .step_w(step_w), .step_i(step_i), .step_f(step_f),
    .step_oa(step_oa), .step_ob(step_ob), .step_oc(step_oc), .step_od(step_od),
    .busy(busy), .done(done),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
  );

  always #5 clk = ~clk;

  int           tests = 0, fails = 0;
  bit           ident = 1'b0;
  logic [127:0] words [32];
  logic [127:0] ma [37], mb [37], mc [37], md [37];
  logic [127:0] sv [4];
  logic [511:0] prev_out = '0;
  int           pi_tab [4][4] = '{'{3, 23, 17, 27}, '{28, 19, 22, 7}, '{29, 9, 15, 5}, '{4, 13, 10, 25}};

  // Expected {r, s, rp, sp, f, i, w_addr} for step n, straight from the rules.
  function automatic logic [27:0] exp_ctrl(input int n);
    int rnd, r, s;
    rnd = (n >= 32) ? 3 : n / 8;
    r   = pi_tab[rnd][n % 4];
    s   = pi_tab[rnd][(n + 1) % 4];
    return {5'(r), 5'(s), 5'((32 - r) % 32), 5'((32 - s) % 32),
            1'((n >= 32) ? 0 : (n / 4) % 2), 2'(n % 3), 5'((n > 31) ? 31 : n)};
  endfunction

  function automatic logic [127:0] exp_w(input int n);
    return (n < 32) ? words[n] : sv[n - 32];
  endfunction

  // External step datapath (arbitrary mixing function, or identity).
  function automatic logic [511:0] dp(input bit id_m, input logic [127:0] a, b, c, d, w,
                                      input logic [22:0] k);
    if (id_m) return {a, b, c, d};
    return {(d ^ w) + 128'(k), a, {b[119:0], b[127:120]}, c + (128'(k) << 64)};
  endfunction

  always_comb {step_oa, step_ob, step_oc, step_od} =
    dp(ident, step_ia, step_ib, step_ic, step_id, step_w,
       {step_r, step_s, step_rp, step_sp, step_f, step_i});
  always_comb w_data = words[w_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    iv_a = {$urandom, $urandom, $urandom, $urandom};
    iv_b = {$urandom, $urandom, $urandom, $urandom};
    iv_c = {$urandom, $urandom, $urandom, $urandom};
    iv_d = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 32; j++) words[j] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic build_model();
    logic [27:0] c;
    sv[0] = iv_a; sv[1] = iv_b; sv[2] = iv_c; sv[3] = iv_d;
    ma[0] = iv_a; mb[0] = iv_b; mc[0] = iv_c; md[0] = iv_d;
    for (int n = 0; n < NSTEPS; n++) begin
      c = exp_ctrl(n);
      {ma[n+1], mb[n+1], mc[n+1], md[n+1]} = dp(ident, ma[n], mb[n], mc[n], md[n], exp_w(n), c[27:5]);
    end
  endtask

  // mode 0: w_valid always 1, 1: random stalls, 2: ten stall cycles in step 12 EXEC.
  task automatic run_scenario(input int mode, output int done_cyc, output int busy_cnt);
    int n, cyc, stall_left;
    bit exec, v;
    logic [511:0] fin;
    build_model();
    fin = {ma[NSTEPS], mb[NSTEPS], mc[NSTEPS], md[NSTEPS]};
    n = 0; exec = 0; busy_cnt = 0; done_cyc = -1; stall_left = 10;
    start = 1; w_valid = 1; tick(); start = 0; cyc = 1;
    while (n < NSTEPS && cyc < 600) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0)
        begin fails++; $display("FAIL busy_done step %0d: got busy=%b done=%b expected busy=1 done=0", n, busy, done); end
      tests++;
      if ({step_r, step_s, step_rp, step_sp, step_f, step_i, w_addr} !== exp_ctrl(n))
        begin fails++; $display("FAIL ctrl step %0d: got %h expected %h", n,
          {step_r, step_s, step_rp, step_sp, step_f, step_i, w_addr}, exp_ctrl(n)); end
      tests++;
      if ({step_ia, step_ib, step_ic, step_id} !== {ma[n], mb[n], mc[n], md[n]})
        begin fails++; $display("FAIL state step %0d: got %h expected %h", n, step_ia, ma[n]); end
      tests++;
      if ({out_a, out_b, out_c, out_d} !== prev_out)
        begin fails++; $display("FAIL out_hold step %0d: got %h expected %h", n, out_a, prev_out[511:384]); end
      if (exec) begin
        tests++;
        if (step_w !== exp_w(n))
          begin fails++; $display("FAIL step_w step %0d: got %h expected %h", n, step_w, exp_w(n)); end
      end
      busy_cnt++;
      if (!exec) exec = 1;
      else begin
        if (mode == 0) v = 1;
        else if (mode == 1) v = ($urandom_range(3) != 0);
        else v = !(n == 12 && stall_left > 0);
        if (mode == 2 && n == 12 && stall_left > 0) stall_left--;
        w_valid = v;
        if (v || n >= 32) begin n++; exec = 0; end
      end
      start = ($urandom_range(5) == 0);
      iv_a = {$urandom, $urandom, $urandom, $urandom};
      tick(); cyc++;
    end
    start = 0; w_valid = 1;
    tests++;
    if (n < NSTEPS || done !== 1'b1 || busy !== 1'b0 || {out_a, out_b, out_c, out_d} !== fin)
      begin fails++; $display("FAIL done_out: got done=%b busy=%b out_a=%h expected done=1 busy=0 out_a=%h (steps %0d)",
        done, busy, out_a, fin[511:384], n); end
    done_cyc = cyc;
    prev_out = fin;
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || {out_a, out_b, out_c, out_d} !== prev_out)
      begin fails++; $display("FAIL after_done: got done=%b busy=%b out_a=%h expected 0 0 %h", done, busy, out_a, prev_out[511:384]); end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0;
    tick(); tick();
    tests++;
    if ({busy, done, w_addr, step_r, step_s, step_rp, step_sp, step_i, step_f} !== 25'd0 ||
        {step_ia, step_ib, step_ic, step_id, step_w, out_a, out_b, out_c, out_d} !== '0)
      begin fails++; $display("FAIL reset_state: got busy=%b done=%b w_addr=%0d r=%0d out_a=%h expected all zero",
        busy, done, w_addr, step_r, out_a); end
    rst_n = 1; w_valid = 1;
    tick(); tick();
    tests++;
    if ({busy, done, w_addr, step_r, step_i, step_f} !== 15'd0 || step_w !== '0)
      begin fails++; $display("FAIL idle_state: got busy=%b done=%b w_addr=%0d r=%0d expected zeros", busy, done, w_addr, step_r); end
  endtask

  task automatic test_spot_steps();
    logic [22:0] e5, e31;
    int k;
    e5  = {5'd23, 5'd17, 5'd9, 5'd15, 1'b1, 2'd2};
    e31 = {5'd25, 5'd4, 5'd7, 5'd28, 1'b1, 2'd1};
    randomize_inputs(); build_model();
    start = 1; w_valid = 1; tick(); start = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (cyc == 12) begin
        tests++;
        if ({step_r, step_s, step_rp, step_sp, step_f, step_i} !== e5)
          begin fails++; $display("FAIL step5_ctrl: got %h expected %h", {step_r, step_s, step_rp, step_sp, step_f, step_i}, e5); end
      end
      if (cyc == 64) begin
        tests++;
        if ({step_r, step_s, step_rp, step_sp, step_f, step_i} !== e31 || w_addr !== 5'd31)
          begin fails++; $display("FAIL step31_ctrl: got %h w_addr=%0d expected %h w_addr=31",
            {step_r, step_s, step_rp, step_sp, step_f, step_i}, w_addr, e31); end
      end
      tick();
    end
    k = 0;
    while (done !== 1'b1 && k < 20) begin tick(); k++; end
    tests++;
    if (done !== 1'b1 || {out_a, out_b, out_c, out_d} !== {ma[NSTEPS], mb[NSTEPS], mc[NSTEPS], md[NSTEPS]})
      begin fails++; $display("FAIL spot_final: got done=%b out_a=%h expected done=1 out_a=%h", done, out_a, ma[NSTEPS]); end
    prev_out = {ma[NSTEPS], mb[NSTEPS], mc[NSTEPS], md[NSTEPS]};
    tick();
  endtask

  task automatic test_timing();
    int dc, bc;
    randomize_inputs();
    run_scenario(0, dc, bc);
    tests++;
    if (dc !== 2 * NSTEPS + 1 || bc !== 2 * NSTEPS)
      begin fails++; $display("FAIL timing: got done_cycle=%0d busy_cycles=%0d expected %0d %0d", dc, bc, 2 * NSTEPS + 1, 2 * NSTEPS); end
  endtask

  task automatic test_stall();
    int dc, bc;
    randomize_inputs();
    run_scenario(2, dc, bc);
    tests++;
    if (dc !== 2 * NSTEPS + 11 || bc !== 2 * NSTEPS + 10)
      begin fails++; $display("FAIL stall_delay: got done_cycle=%0d busy_cycles=%0d expected %0d %0d", dc, bc, 2 * NSTEPS + 11, 2 * NSTEPS + 10); end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    for (int r = 0; r < 3; r++) begin
      randomize_inputs();
      run_scenario(1, dc, bc);
    end
  endtask

  task automatic test_reset_midrun();
    int k, bad;
    randomize_inputs(); build_model();
    start = 1; w_valid = 1; tick(); start = 0;
    k = 0;
    while (w_addr !== 5'd20 && k < 100) begin tick(); k++; end
    tests++;
    if (w_addr !== 5'd20)
      begin fails++; $display("FAIL reach_step20: got w_addr=%0d expected 20", w_addr); end
    rst_n = 0;
    #1;
    tests++;
    if ({busy, done, w_addr, step_r, step_i, step_f} !== 15'd0 ||
        {out_a, out_b, out_c, out_d, step_ia, step_w} !== '0)
      begin fails++; $display("FAIL midrun_reset: got busy=%b done=%b w_addr=%0d out_a=%h step_ia=%h expected zeros",
        busy, done, w_addr, out_a, step_ia); end
    prev_out = '0;
    start = 1; tick(); tick(); start = 0;
    rst_n = 1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    tests++;
    if (bad !== 0)
      begin fails++; $display("FAIL no_completion: got %0d active cycles after release expected 0", bad); end
    test_timing();
  endtask

  task automatic test_identity();
    int dc, bc;
    logic [127:0] pat;
    pat = {4{32'h01234567}};
    ident = 1;
    randomize_inputs();
    iv_a = pat;
    run_scenario(1, dc, bc);
    tests++;
    if (prev_out[511:384] !== pat || out_a !== pat)
      begin fails++; $display("FAIL identity_out_a: got %h expected %h", out_a, pat); end
    ident = 0;
  endtask

  initial begin
    test_reset();
    test_spot_steps();
    test_timing();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    test_identity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
